s3g_packet_tx: RTL and testbench

Byte-level S3G packet transmitter, the transmit counterpart of `s3g_rx`. It sits between a payload buffer and `uart_transceiver`. It frames a payload held in an addressed buffer as start byte, length, payload and CRC8, and feeds the frame to the UART one byte at a time using the `tx_wr`/`tx_done` handshake. Its payload-side interface uses the same addressed byte-buffer style as `s3g_rx` (`buffer_addr` out / `buffer_data` in), so the executor or a packet RAM can drive it directly.

---
 rtl/s3g_pkg.sv | 32 +++
 rtl/s3g_crc8.sv | 26 ++
 rtl/s3g_packet_tx.sv | 119 +++++++++++
 tb/tb_s3g_packet_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/s3g_pkg.sv
// Shared S3G definitions: framing constants, transmitter states and the
// Dallas/Maxim CRC8 byte update used by both the transmitter and s3g_rx.
package s3g_pkg;

  localparam logic [7:0] S3G_START_BYTE  = 8'hD5;
  localparam logic [7:0] S3G_CRC_POLY    = 8'h8C;
  localparam int         S3G_MAX_PAYLOAD = 32'sd32;

  typedef enum logic [3:0] {
    TX_IDLE       = 4'd0,
    TX_SEND_START = 4'd1,
    TX_WAIT_START = 4'd2,
    TX_SEND_LEN   = 4'd3,
    TX_WAIT_LEN   = 4'd4,
    TX_FETCH      = 4'd5,
    TX_SEND_PAY   = 4'd6,
    TX_WAIT_PAY   = 4'd7,
    TX_SEND_CRC   = 4'd8,
    TX_WAIT_CRC   = 4'd9
  } tx_state_e;

  // Reflected CRC8, LSB first: fold the byte in, then shift out eight bits.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 32'd0; i < 32'd8; i++) begin
      c = c[0] ? ({1'b0, c[7:1]} ^ S3G_CRC_POLY) : {1'b0, c[7:1]};
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_crc8.sv
// Byte-wide CRC8 accumulator; clear has priority over update.
module s3g_crc8
  import s3g_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       update,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (update) begin
      crc <= crc8_update(crc, data);
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/s3g_packet_tx.sv
// S3G frame transmitter: start byte, length, payload from an addressed
// buffer, then CRC8, handed to the UART one byte per tx_wr/tx_done handshake.
module s3g_packet_tx
  import s3g_pkg::*;
#(
  parameter int MAX_PAYLOAD = S3G_MAX_PAYLOAD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       packet_wr,
  input  logic [7:0] payload_len,
  output logic       busy,
  output logic [7:0] buffer_addr,
  input  logic [7:0] buffer_data,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done,
  output logic       packet_sent,
  output logic       len_error
);

  localparam logic [8:0] MAX_LEN_C = 9'(MAX_PAYLOAD);

  tx_state_e  state_r;
  logic [7:0] len_r;
  logic [7:0] crc_s;
  logic       len_ok_s;
  logic       crc_clear_s;
  logic       crc_update_s;

  assign len_ok_s     = (payload_len != 8'd0) && ({1'b0, payload_len} <= MAX_LEN_C);
  assign crc_clear_s  = (state_r == TX_IDLE) && packet_wr && len_ok_s;
  // The RAM word for the current index is stable during FETCH.
  assign crc_update_s = (state_r == TX_FETCH);

  s3g_crc8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (crc_clear_s),
    .update (crc_update_s),
    .data   (buffer_data),
    .crc    (crc_s)
  );

  // Frame sequencer with registered UART strobe, data and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= TX_IDLE;
      len_r       <= 8'd0;
      busy        <= 1'b0;
      buffer_addr <= 8'd0;
      tx_data     <= 8'h00;
      tx_wr       <= 1'b0;
      packet_sent <= 1'b0;
      len_error   <= 1'b0;
    end else begin
      tx_wr       <= 1'b0;
      packet_sent <= 1'b0;
      len_error   <= 1'b0;
      case (state_r)
        TX_IDLE: begin
          if (packet_wr && len_ok_s) begin
            len_r       <= payload_len;
            buffer_addr <= 8'd0;
            busy        <= 1'b1;
            tx_wr       <= 1'b1;
            tx_data     <= S3G_START_BYTE;
            state_r     <= TX_SEND_START;
          end else if (packet_wr) begin
            len_error <= 1'b1;
          end
        end
        TX_SEND_START: state_r <= TX_WAIT_START;
        TX_WAIT_START: begin
          if (tx_done) begin
            tx_wr   <= 1'b1;
            tx_data <= len_r;
            state_r <= TX_SEND_LEN;
          end
        end
        TX_SEND_LEN: state_r <= TX_WAIT_LEN;
        TX_WAIT_LEN: begin
          if (tx_done) begin
            state_r <= TX_FETCH;
          end
        end
        TX_FETCH: begin
          tx_wr       <= 1'b1;
          tx_data     <= buffer_data;
          buffer_addr <= buffer_addr + 8'd1;
          state_r     <= TX_SEND_PAY;
        end
        TX_SEND_PAY: state_r <= TX_WAIT_PAY;
        TX_WAIT_PAY: begin
          if (tx_done && (buffer_addr < len_r)) begin
            state_r <= TX_FETCH;
          end else if (tx_done) begin
            tx_wr   <= 1'b1;
            tx_data <= crc_s;
            state_r <= TX_SEND_CRC;
          end
        end
        TX_SEND_CRC: state_r <= TX_WAIT_CRC;
        TX_WAIT_CRC: begin
          if (tx_done) begin
            packet_sent <= 1'b1;
            busy        <= 1'b0;
            state_r     <= TX_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s3g_packet_tx.sv
// Directed self-checking bench for s3g_packet_tx with a sync-read RAM model
// and a scripted UART responder.
module tb_s3g_packet_tx;

  logic       clk;
  logic       rst;
  logic       packet_wr;
  logic [7:0] payload_len;
  logic       busy;
  logic [7:0] buffer_addr;
  logic [7:0] buffer_data;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;
  logic       packet_sent;
  logic       len_error;

  logic [7:0] mem [0:255];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] addr_log [$];
  int         lat_q [$];
  logic [7:0] addr_prev;
  int         tests = 0;
  int         fails = 0;

  s3g_packet_tx #(.MAX_PAYLOAD(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .packet_wr   (packet_wr),
    .payload_len (payload_len),
    .busy        (busy),
    .buffer_addr (buffer_addr),
    .buffer_data (buffer_data),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_done     (tx_done),
    .packet_sent (packet_sent),
    .len_error   (len_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read payload RAM.
  always @(posedge clk) buffer_data <= mem[buffer_addr];

  // Byte stream and address-change monitor.
  always @(negedge clk) begin
    if (tx_wr) got_q.push_back(tx_data);
    if (buffer_addr != addr_prev) addr_log.push_back(buffer_addr);
    addr_prev <= buffer_addr;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC over mem[0..len-1].
  function automatic logic [7:0] ref_crc(input int len);
    logic [7:0] c;
    logic [7:0] d;
    logic       mix;
    c = 8'h00;
    for (int i = 0; i < len; i++) begin
      d = mem[i];
      for (int b = 0; b < 8; b++) begin
        mix = c[0] ^ d[0];
        c   = c >> 1;
        if (mix) c = c ^ 8'h8C;
        d   = d >> 1;
      end
    end
    return c;
  endfunction

  task automatic expect_frame(input int len);
    exp_q = {};
    exp_q.push_back(8'hD5);
    exp_q.push_back(8'(len));
    for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
    exp_q.push_back(ref_crc(len));
  endtask

  task automatic check_stream(input string tag);
    check($sformatf("%s_nbytes", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // Request a frame and answer nd bytes; spur adds ignored tx_done pulses in
  // SEND/FETCH states, ign issues an ignored packet_wr while busy.
  task automatic run_packet(input int len, input int nd, input int lat_lo, input int lat_hi,
                            input bit spur, input bit ign);
    int waited;
    int lat;
    got_q = {};
    lat_q = {};
    payload_len = 8'(len);
    packet_wr   = 1'b1;
    tick();
    packet_wr = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_wr", 32'(tx_wr), 32'd1);
    check("start_byte", 32'(tx_data), 32'hD5);
    for (int i = 0; i < nd; i++) begin
      waited = 0;
      while (!tx_wr && waited < 400) begin
        tx_done = spur;
        tick();
        tx_done = 1'b0;
        waited++;
      end
      if (!tx_wr) begin
        check("wr_timeout", 32'(tx_wr), 32'd1);
        return;
      end
      lat_q.push_back(waited);
      lat = int'($urandom_range(lat_hi, lat_lo));
      tx_done = spur;
      tick();
      tx_done = 1'b0;
      for (int k = 1; k < lat; k++) begin
        if (ign && i == 1 && k == 1) begin
          packet_wr   = 1'b1;
          payload_len = 8'd3;
        end
        tick();
        packet_wr = 1'b0;
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    if (nd == len + 3) begin
      check("sent_pulse", 32'(packet_sent), 32'd1);
      check("busy_clear", 32'(busy), 32'd0);
    end
  endtask

  logic [7:0] std_exp [0:11];

  initial begin
    rst = 1'b1; packet_wr = 1'b0; payload_len = 8'd0; tx_done = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) tick();
    check("rst_tx_wr", 32'(tx_wr), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(buffer_addr), 32'd0);
    check("rst_sent", 32'(packet_sent), 32'd0);
    check("rst_len_error", 32'(len_error), 32'd0);
    rst = 1'b0;
    tick();

    // Standard CRC vector "123456789" -> A1.
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    std_exp = '{8'hD5, 8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hA1};
    run_packet(9, 12, 1, 3, 1'b0, 1'b0);
    check("std_nbytes", 32'(got_q.size()), 32'd12);
    for (int i = 0; i < 12 && i < got_q.size(); i++)
      check($sformatf("std_byte%0d", i), 32'(got_q[i]), 32'(std_exp[i]));
    for (int i = 0; i < 12 && i < lat_q.size(); i++)
      check($sformatf("std_lat%0d", i), 32'(lat_q[i]), (i >= 2 && i <= 10) ? 32'd1 : 32'd0);
    tick();
    check("std_sent_one_cycle", 32'(packet_sent), 32'd0);
    check("std_addr_hold", 32'(buffer_addr), 32'd9);

    // Single zero byte.
    mem[0] = 8'h00;
    run_packet(1, 4, 1, 1, 1'b0, 1'b0);
    exp_q = '{8'hD5, 8'h01, 8'h00, 8'h00};
    check_stream("zero");
    tick();

    // Length rejection: 0 and MAX_PAYLOAD+1.
    got_q = {};
    payload_len = 8'd0; packet_wr = 1'b1; tick(); packet_wr = 1'b0;
    check("rej0_len_error", 32'(len_error), 32'd1);
    check("rej0_busy", 32'(busy), 32'd0);
    check("rej0_wr", 32'(tx_wr), 32'd0);
    tick();
    check("rej0_pulse_end", 32'(len_error), 32'd0);
    payload_len = 8'd33; packet_wr = 1'b1; tick(); packet_wr = 1'b0;
    check("rej33_len_error", 32'(len_error), 32'd1);
    check("rej33_busy", 32'(busy), 32'd0);
    tick();
    check("rej33_pulse_end", 32'(len_error), 32'd0);
    repeat (3) tick();
    check("rej_no_wr", 32'(got_q.size()), 32'd0);

    // Ignored request while busy, spurious tx_done, back-to-back frames.
    mem[0] = 8'h10; mem[1] = 8'h20;
    run_packet(2, 5, 2, 4, 1'b1, 1'b1);
    expect_frame(2);
    check_stream("b2b_a");
    run_packet(1, 4, 1, 3, 1'b1, 1'b0);
    repeat (5) tick();
    check("b2b_idle_busy", 32'(busy), 32'd0);
    expect_frame(1);
    check_stream("b2b_b");

    // Reset after the 3rd tx_done of a len=9 frame.
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    run_packet(9, 3, 1, 2, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_rst_wr", 32'(tx_wr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(buffer_addr), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'h00);
    check("mid_rst_sent", 32'(packet_sent), 32'd0);
    check("mid_rst_len_error", 32'(len_error), 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("mid_rst_no_more_wr", 32'(got_q.size()), 32'd3);
    mem[0] = 8'h5A;
    run_packet(1, 4, 1, 5, 1'b0, 1'b0);
    expect_frame(1);
    check_stream("after_rst");
    tick();

    // Random UART latency with a maximum-length payload.
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    addr_log = {};
    run_packet(32, 35, 1, 200, 1'b0, 1'b0);
    expect_frame(32);
    check_stream("stress");
    check("stress_addr_changes", 32'(addr_log.size()), 32'd33);
    for (int i = 0; i < 33 && i < addr_log.size(); i++)
      check($sformatf("stress_addr%0d", i), 32'(addr_log[i]), 32'(i));
    check("stress_addr_hold", 32'(buffer_addr), 32'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
